// File: rtl/bit_cell_render_if.sv
// bit_cell_render_if
//   Pixel-stream bundle between the timing generator / line_map side and the
//   bit cell renderer, plus the renderer's outputs toward the VGA pins.
//   Signals:
//     col          raw column from the timing generator
//     hsync_in     raw hsync
//     vsync_in     raw vsync
//     video_on_in  raw active-video flag
//     data         selected 16-bit word (one clk behind col)
//     all          blank flag for the row (one clk behind col)
//     rgb          RGB332 pixel out
//     hsync_out    hsync delayed to match rgb
//     vsync_out    vsync delayed to match rgb
//   master: the stream source (drives the inputs, observes the outputs)
//   slave : the renderer
interface bit_cell_render_if;
  logic [10:0] col;
  logic        hsync_in;
  logic        vsync_in;
  logic        video_on_in;
  logic [15:0] data;
  logic        all;
  logic [7:0]  rgb;
  logic        hsync_out;
  logic        vsync_out;

  modport master (
    output col, hsync_in, vsync_in, video_on_in, data, all,
    input  rgb, hsync_out, vsync_out
  );

  modport slave (
    input  col, hsync_in, vsync_in, video_on_in, data, all,
    output rgb, hsync_out, vsync_out
  );
endinterface

// File: rtl/bit_cell_render.sv
// bit_cell_render
//   Draws a 16-bit word as 16 horizontal bit cells (MSB leftmost) on a VGA
//   line, with wider gaps at nibble boundaries. Three-register pipeline:
//   col -> rgb latency is 3 clk, and the syncs are delayed to match.
//   Ports:
//     clk    pixel clock
//     reset  asynchronous, active-high
//     bus    bit_cell_render_if.slave (col, syncs, video_on, data, all in;
//            rgb, hsync_out, vsync_out out)
module bit_cell_render #(
  parameter int          X0        = 100,
  parameter int          CELL_W    = 32,
  parameter int          GAP       = 4,
  parameter int          NIB_GAP   = 12,
  parameter logic [7:0]  ON_COLOR  = 8'hFC,
  parameter logic [7:0]  OFF_COLOR = 8'h49,
  parameter logic [7:0]  BG_COLOR  = 8'h03
) (
  input  logic               clk,
  input  logic               reset,
  bit_cell_render_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_CELL, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {CLS_BG, CLS_OFF, CLS_ON} cls_t;

  localparam logic [10:0] LP_X0       = 11'(X0);
  localparam logic [5:0]  LP_CELL_END = 6'(CELL_W - 1);
  localparam logic [5:0]  LP_GAP_END  = 6'(GAP - 1);
  localparam logic [5:0]  LP_NIB_END  = 6'(NIB_GAP - 1);

  function automatic logic [7:0] f_color(input cls_t cls, input logic vld);
    logic [7:0] c;
    case (cls)
      CLS_ON:  c = ON_COLOR;
      CLS_OFF: c = OFF_COLOR;
      default: c = BG_COLOR;
    endcase
    return vld ? c : 8'h00;
  endfunction

  // Stage 1 registers
  logic [10:0] r_col_p1;
  logic        r_hs_p1, r_vs_p1, r_vld_p1;
  // Stage 2 registers (FSM state and pixel class)
  state_t      r_state;
  logic [3:0]  r_cell;
  logic [5:0]  r_pix;
  logic [15:0] r_word;
  logic        r_blank;
  cls_t        r_cls_p2;
  logic        r_hs_p2, r_vs_p2, r_vld_p2;
  // Stage 3 registers
  logic [7:0]  r_rgb_p3;
  logic        r_hs_p3, r_vs_p3;

  state_t      w_state_n;
  logic [3:0]  w_cell_n;
  logic [5:0]  w_pix_n;
  logic [15:0] w_word_n;
  logic        w_blank_n;
  logic [5:0]  w_gap_end;
  cls_t        w_cls_n;

  // The gap following cells 12, 8 and 4 is the wide nibble gap.
  assign w_gap_end = (r_cell[1:0] == 2'b00) ? LP_NIB_END : LP_GAP_END;

  // data/all arrive already aligned with r_col_p1, so they are consumed here
  // without a register of their own.
  always_comb begin
    w_state_n = r_state;
    w_cell_n  = r_cell;
    w_pix_n   = r_pix;
    w_word_n  = r_word;
    w_blank_n = r_blank;
    if (r_col_p1 == LP_X0) begin
      // Restart at the first column wins over every other transition, which
      // also resynchronises the FSM after any column discontinuity.
      w_state_n = S_CELL;
      w_cell_n  = 4'd15;
      w_pix_n   = 6'd0;
      w_word_n  = bus.data;
      w_blank_n = bus.all;
    end else begin
      case (r_state)
        S_CELL: begin
          if (r_pix == LP_CELL_END) begin
            if (r_cell == 4'd0) begin
              w_state_n = S_DONE;
            end else begin
              w_state_n = S_GAP;
              w_pix_n   = 6'd0;
            end
          end else begin
            w_pix_n = r_pix + 6'd1;
          end
        end
        S_GAP: begin
          if (r_pix == w_gap_end) begin
            w_state_n = S_CELL;
            w_pix_n   = 6'd0;
            w_cell_n  = r_cell - 4'd1;
          end else begin
            w_pix_n = r_pix + 6'd1;
          end
        end
        S_DONE: begin
          if (r_col_p1 == 11'd0) w_state_n = S_IDLE;
        end
        default: ;
      endcase
    end

    // Class is derived from the next state so that it lands in the same
    // register stage as the state itself.
    w_cls_n = CLS_BG;
    if (w_state_n == S_CELL && !w_blank_n)
      w_cls_n = w_word_n[w_cell_n] ? CLS_ON : CLS_OFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col_p1 <= '0;
      r_hs_p1  <= 1'b1;
      r_vs_p1  <= 1'b1;
      r_vld_p1 <= 1'b0;
      r_state  <= S_IDLE;
      r_cell   <= 4'd15;
      r_pix    <= 6'd0;
      r_word   <= 16'h0000;
      r_blank  <= 1'b1;
      r_cls_p2 <= CLS_BG;
      r_hs_p2  <= 1'b1;
      r_vs_p2  <= 1'b1;
      r_vld_p2 <= 1'b0;
      r_rgb_p3 <= 8'h00;
      r_hs_p3  <= 1'b1;
      r_vs_p3  <= 1'b1;
    end else begin
      // Stage 1: capture raw timing
      r_col_p1 <= bus.col;
      r_hs_p1  <= bus.hsync_in;
      r_vs_p1  <= bus.vsync_in;
      r_vld_p1 <= bus.video_on_in;
      // Stage 2: FSM advance and pixel class
      r_state  <= w_state_n;
      r_cell   <= w_cell_n;
      r_pix    <= w_pix_n;
      r_word   <= w_word_n;
      r_blank  <= w_blank_n;
      r_cls_p2 <= w_cls_n;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_vld_p2 <= r_vld_p1;
      // Stage 3: colour map and blanking
      r_rgb_p3 <= f_color(r_cls_p2, r_vld_p2);
      r_hs_p3  <= r_hs_p2;
      r_vs_p3  <= r_vs_p2;
    end
  end

  assign bus.rgb       = r_rgb_p3;
  assign bus.hsync_out = r_hs_p3;
  assign bus.vsync_out = r_vs_p3;

endmodule

// File: tb/tb_bit_cell_render.sv
// tb_bit_cell_render
//   Directed line sweeps against two renderers: default geometry, and a
//   compact geometry (CELL_W=8, GAP=1, NIB_GAP=3) fed a constant 16'h8001.
module tb_bit_cell_render;

  localparam logic [7:0] ON  = 8'hFC;
  localparam logic [7:0] OFF = 8'h49;
  localparam logic [7:0] BG  = 8'h03;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bit_cell_render_if bus1 ();
  bit_cell_render_if bus2 ();

  bit_cell_render dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  bit_cell_render #(
    .CELL_W  (8),
    .GAP     (1),
    .NIB_GAP (3)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  typedef struct {
    int         col;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int total = 0;
  int bad   = 0;

  logic [15:0] d1_prev = 16'h0000;
  logic        a1_prev = 1'b0;
  logic [15:0] d2_prev = 16'h8001;

  // Geometric reference: walk cell start positions left to right.
  function automatic logic [7:0] exp_rgb(input int c, input logic von,
                                         input logic [15:0] word, input logic blank,
                                         input int cw, input int g, input int ng);
    int pos;
    if (!von) return 8'h00;
    if (blank) return BG;
    pos = 100;
    for (int k = 15; k >= 0; k--) begin
      if (c >= pos && c < pos + cw) return word[k] ? ON : OFF;
      pos = pos + cw;
      if (k != 0) pos = pos + (((k % 4) == 0) ? ng : g);
    end
    return BG;
  endfunction

  task automatic chk(input string tag, input int col, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s col=%0d observed=%0h expected=%0h", tag, col, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag, input int col);
    chk({tag, "_rgb1"}, col, bus1.rgb, 8'h00);
    chk({tag, "_hs1"},  col, {7'b0, bus1.hsync_out}, 8'h01);
    chk({tag, "_vs1"},  col, {7'b0, bus1.vsync_out}, 8'h01);
    chk({tag, "_rgb2"}, col, bus2.rgb, 8'h00);
  endtask

  task automatic prefill();
    exp_t e;
    e.col = -1; e.rgb = 8'h00; e.hs = 1'b1; e.vs = 1'b1;
    q1.delete(); q2.delete();
    repeat (2) begin q1.push_back(e); q2.push_back(e); end
  endtask

  task automatic compare_front();
    exp_t e;
    if (q1.size() == 3) begin
      e = q1.pop_front();
      chk("d1_rgb", e.col, bus1.rgb, e.rgb);
      chk("d1_hsync", e.col, {7'b0, bus1.hsync_out}, {7'b0, e.hs});
      chk("d1_vsync", e.col, {7'b0, bus1.vsync_out}, {7'b0, e.vs});
    end
    if (q2.size() == 3) begin
      e = q2.pop_front();
      chk("d2_rgb", e.col, bus2.rgb, e.rgb);
      chk("d2_hsync", e.col, {7'b0, bus2.hsync_out}, {7'b0, e.hs});
    end
  endtask

  // One 800-column line. chg_col switches the presented word mid-line;
  // rs/re bound a reset window (rs < 0 for none).
  task automatic sweep(input logic [15:0] line_d, input logic line_all,
                       input logic von, input int chg_col, input logic [15:0] chg_d,
                       input int rs, input int re, input logic vs_pulse);
    logic [15:0] dnow;
    logic        hs, vs;
    exp_t        e1, e2;
    for (int c = 0; c < 800; c++) begin
      dnow = (c >= chg_col) ? chg_d : line_d;
      hs   = !(c >= 656 && c < 752);
      vs   = !(vs_pulse && c < 2);
      bus1.col = 11'(c); bus1.hsync_in = hs; bus1.vsync_in = vs; bus1.video_on_in = von;
      bus1.data = d1_prev; bus1.all = a1_prev;
      d1_prev = dnow; a1_prev = line_all;
      bus2.col = 11'(c); bus2.hsync_in = hs; bus2.vsync_in = vs; bus2.video_on_in = von;
      bus2.data = d2_prev; bus2.all = 1'b0;
      d2_prev = 16'h8001;
      if (rs >= 0 && c >= rs && c < re) begin
        reset = 1'b1;
        q1.delete(); q2.delete();
        #1;
        chk_reset_outputs("rst_async", c);
        @(posedge clk); #1;
        chk_reset_outputs("rst_held", c);
      end else begin
        if (rs >= 0 && c == re) begin
          reset = 1'b0;
          prefill();
        end
        e1.col = c; e1.hs = hs; e1.vs = vs;
        e2.col = c; e2.hs = hs; e2.vs = vs;
        if (rs >= 0 && c >= rs) begin
          e1.rgb = von ? BG : 8'h00;
          e2.rgb = von ? BG : 8'h00;
        end else begin
          e1.rgb = exp_rgb(c, von, line_d, line_all, 32, 4, 12);
          e2.rgb = exp_rgb(c, von, 16'h8001, 1'b0, 8, 1, 3);
        end
        q1.push_back(e1); q2.push_back(e2);
        @(posedge clk); #1;
        compare_front();
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus1.col = '0; bus1.hsync_in = 1'b1; bus1.vsync_in = 1'b1;
    bus1.video_on_in = 1'b0; bus1.data = '0; bus1.all = 1'b0;
    bus2.col = '0; bus2.hsync_in = 1'b1; bus2.vsync_in = 1'b1;
    bus2.video_on_in = 1'b0; bus2.data = 16'h8001; bus2.all = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_state", 0);

    reset = 1'b0;
    prefill();
    // A5C3 with a vsync pulse at the start of the line
    sweep(16'hA5C3, 1'b0, 1'b1, 9999, 16'h0000, -1, -1, 1'b1);
    // blank row
    sweep(16'hA5C3, 1'b1, 1'b1, 9999, 16'h0000, -1, -1, 1'b0);
    // video off
    sweep(16'hA5C3, 1'b0, 1'b0, 9999, 16'h0000, -1, -1, 1'b0);
    // word changes mid-line; the latched FFFF must persist
    sweep(16'hFFFF, 1'b0, 1'b1, 300, 16'h0000, -1, -1, 1'b0);
    // next line picks up 0000
    sweep(16'h0000, 1'b0, 1'b1, 9999, 16'h0000, -1, -1, 1'b0);
    // reset pulse mid-line
    sweep(16'hA5C3, 1'b0, 1'b1, 9999, 16'h0000, 400, 410, 1'b0);
    // full recovery on the following line
    sweep(16'hA5C3, 1'b0, 1'b1, 9999, 16'h0000, -1, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
